pwm_s8: RTL and testbench
=========================

Name: pwm_s8

Overview:
- Instruction-driven 8-bit PWM generator that sits directly downstream of the 8-bit register bank.
- Duty is loaded from the instruction immediate, or captured from the bank's 8-bit output via data_in.
- Uses the same 12-bit instruction format as the bank: code in [11:8], immediate in [7:0], qualified by inst_en.
- Drives a single PWM pin and a period-done strobe for the sequencer.

Parameters:
- DIV_WIDTH, 8, width of the prescaler register and prescaler counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- inst  in  12  instruction: [11:8] code, [7:0] immediate.
- inst_en  in  1  instruction valid; inst is ignored when low.
- data_in  in  8  external duty source, connected to the register bank output.
- pwm  out  1  PWM output.
- period_done  out  1  one-cycle strobe at the end of each PWM period.
- error  out  1  high while in the Error state.

Behaviour:
- Reset is synchronous, active-high; clock is clock.
- Opcodes:
  - 0 NOP.
  - 1 LDD: duty <= imm.
  - 2 LDX: duty <= data_in, sampled in the same cycle as inst_en.
  - 3 LDP: presc <= imm, zero-extended or truncated to DIV_WIDTH.
  - 4 RUN.
  - 5 STP.
  - 6..F: illegal.
- State machine, 2-bit: Reset, Stop, Run, Error.
- reset high: next edge gives state=Reset; duty, duty_act, presc, pcnt and cnt all 0.
- While in reset and in Reset/Stop/Error: pwm=0, period_done=0. error=0 except in Error.
- Reset state: one cycle, clears all registers, goes unconditionally to Stop. inst is ignored in Reset.
- Stop state:
  - pcnt=0, cnt=0.
  - duty_act <= duty every cycle (shadow is transparent while stopped).
  - LDD/LDX/LDP update their register and the state stays Stop.
  - RUN: next state Run, pcnt=0, cnt=0, duty_act <= duty. If LDD/LDX arrived the cycle before, the new duty is used.
  - STP/NOP: no effect.
  - Illegal code: Error.
- Run state:
  - tick = (pcnt == presc).
  - On tick: pcnt <= 0 and cnt <= cnt+1 (8-bit wrap, 255 -> 0). Otherwise pcnt <= pcnt+1.
  - presc=0 ticks every cycle. Period = 256*(presc+1) clocks.
  - pwm = (cnt < duty_act), combinational from registers.
    - duty 0: constant 0.
    - duty 255: high 255 of every 256 counts. 100% duty is not reachable by design.
  - Wrap event = tick && cnt==255. On a wrap:
    - duty_act <= duty, so a duty change only takes effect at a period boundary (glitch-free).
    - period_done = 1 for that cycle (combinational from the wrap condition).
  - LDD/LDX update duty (shadow only).
  - LDP updates presc immediately; the tick comparison uses the new value from the next cycle.
    - If pcnt > new presc, pcnt counts up to the DIV_WIDTH wrap and then restarts. This is legal and expected; no correction is applied.
  - RUN: no effect; counters continue.
  - STP: next state Stop, pcnt=0, cnt=0, pwm=0 from the next cycle.
  - Illegal code: Error.
- Simultaneous wrap and LDD in the same cycle: duty_act takes the old duty (the register value before the edge). The new duty applies at the following wrap.
- Error state:
  - Sticky; only reset exits it.
  - All registers are held at 0.
  - pwm=0, period_done=0, error=1.
  - inst is ignored.
- Undefined state encoding: go to Error.
- inst_en low: behaves as NOP.
- Reset mid-Run: pwm drops to 0 on the next edge. Configuration is lost; RUN must be reissued after reset.

Test Plan:
- Reset, then LDD 40h, RUN with presc=0:
  - pwm is high for counts 0..63 and low for 64..255, i.e. 64 clocks high then 192 low, repeating.
  - period_done pulses every 256 clocks, coincident with cnt 255.
- LDP 03h, LDD 80h, RUN:
  - period is 1024 clocks, pwm is high for 512 clocks.
  - with presc=3, each count lasts 4 clocks.
- Duty update mid-period:
  - While running with duty 40h, issue LDD C0h at cnt=10h.
  - The current period keeps 64 high clocks; the next period has 192 high clocks.
  - Repeat with LDD in the exact wrap cycle: the change is delayed by one full period.
- data_in=5Ah with LDX in Stop, then RUN:
  - pwm is high for 90 clocks per period.
  - Check duty 00h (pwm never high) and FFh (255 high clocks, 1 low).
- STP at cnt=30h:
  - pwm is 0 from the next cycle and period_done stays 0.
  - A following RUN restarts from cnt=0 with the full high phase.
- Inst code 7h with inst_en=1 while running:
  - next cycle error=1 and pwm=0.
  - subsequent RUN/LDD are ignored.
  - reset returns to Stop in 2 cycles with error=0.

Source files
------------

// File: rtl/pwm_s8.sv
// Instruction-driven 8-bit PWM generator with a prescaler and a shadowed duty.
// Duty changes reach the output only at a period boundary, which keeps the pulse glitch-free.
module pwm_s8 #(
  parameter int DIV_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  input  logic [7:0]  data_in,
  output logic        pwm,
  output logic        period_done,
  output logic        error
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDD = 4'h1;
  localparam logic [3:0] OP_LDX = 4'h2;
  localparam logic [3:0] OP_LDP = 4'h3;
  localparam logic [3:0] OP_RUN = 4'h4;
  localparam logic [3:0] OP_STP = 4'h5;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_STOP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t               state;
  logic [7:0]           duty;
  logic [7:0]           duty_act;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] pcnt;
  logic [7:0]           cnt;

  logic [3:0]           code;
  logic [7:0]           imm;
  logic [DIV_WIDTH-1:0] imm_ext;
  logic                 tick;
  logic                 wrap;

  assign code = inst_en ? inst[11:8] : OP_NOP;
  assign imm  = inst[7:0];

  // Immediate is zero-extended or truncated to the prescaler width.
  for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_imm_ext
    if (gi < 8) begin : g_bit
      assign imm_ext[gi] = imm[gi];
    end else begin : g_zero
      assign imm_ext[gi] = 1'b0;
    end
  end

  assign tick = (pcnt == presc);
  assign wrap = tick && (cnt == 8'hFF);

  assign pwm         = (state == ST_RUN) && (cnt < duty_act);
  assign period_done = (state == ST_RUN) && wrap;
  assign error       = (state == ST_ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RESET;
      duty     <= '0;
      duty_act <= '0;
      presc    <= '0;
      pcnt     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_STOP;
          duty     <= '0;
          duty_act <= '0;
          presc    <= '0;
          pcnt     <= '0;
          cnt      <= '0;
        end

        ST_STOP: begin
          pcnt     <= '0;
          cnt      <= '0;
          duty_act <= duty;
          case (code)
            OP_NOP, OP_STP: ;
            OP_LDD: duty  <= imm;
            OP_LDX: duty  <= data_in;
            OP_LDP: presc <= imm_ext;
            OP_RUN: state <= ST_RUN;
            default: begin
              state    <= ST_ERROR;
              duty     <= '0;
              duty_act <= '0;
              presc    <= '0;
            end
          endcase
        end

        ST_RUN: begin
          if (tick) begin
            pcnt <= '0;
            cnt  <= cnt + 8'd1;
            if (cnt == 8'hFF) duty_act <= duty;
          end else begin
            pcnt <= pcnt + DIV_WIDTH'(1);
          end
          // Instruction effects below override the counter update where they collide.
          case (code)
            OP_NOP, OP_RUN: ;
            OP_LDD: duty  <= imm;
            OP_LDX: duty  <= data_in;
            OP_LDP: presc <= imm_ext;
            OP_STP: begin
              state <= ST_STOP;
              pcnt  <= '0;
              cnt   <= '0;
            end
            default: begin
              state    <= ST_ERROR;
              duty     <= '0;
              duty_act <= '0;
              presc    <= '0;
              pcnt     <= '0;
              cnt      <= '0;
            end
          endcase
        end

        default: begin
          state    <= ST_ERROR;
          duty     <= '0;
          duty_act <= '0;
          presc    <= '0;
          pcnt     <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_s8.sv
// Scoreboard bench for pwm_s8: stimulus queues expected per-period results and
// level probes; a negedge monitor pops and compares them.
module tb_pwm_s8;

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic [7:0]  data_in;
  logic        pwm;
  logic        period_done;
  logic        error;

  pwm_s8 #(.DIV_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .inst        (inst),
    .inst_en     (inst_en),
    .data_in     (data_in),
    .pwm         (pwm),
    .period_done (period_done),
    .error       (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int hi;
    int len;
  } period_t;

  typedef struct {
    string name;
    int    act;
    int    req;
  } probe_t;

  period_t exp_q[$];
  probe_t  chk_q[$];

  int checks = 0;
  int errors = 0;
  int run_id = 0;
  int seen_id = 0;
  int hi_cnt = 0;
  int len_cnt = 0;
  int n_period = 0;

  localparam logic [3:0] LDD = 4'h1;
  localparam logic [3:0] LDX = 4'h2;
  localparam logic [3:0] LDP = 4'h3;
  localparam logic [3:0] RUN = 4'h4;
  localparam logic [3:0] STP = 4'h5;

  // Monitor: sole owner of the counters; judges period summaries and queued probes.
  always @(negedge clock) begin
    period_t e;
    probe_t  p;
    while (chk_q.size() > 0) begin
      p = chk_q.pop_front();
      checks++;
      if (p.act != p.req) begin
        errors++;
        $display("FAIL %s actual=%0d required=%0d", p.name, p.act, p.req);
      end else begin
        $display("probe %s = %0d", p.name, p.act);
      end
    end
    if (run_id != seen_id) begin
      seen_id = run_id;
      hi_cnt  = 0;
      len_cnt = 0;
    end
    len_cnt++;
    if (pwm === 1'b1) hi_cnt++;
    if (period_done === 1'b1) begin
      n_period++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_period_done actual=1 required=0 (period %0d)", n_period);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (hi_cnt != e.hi) begin
          errors++;
          $display("FAIL period_high actual=%0d required=%0d (period %0d)", hi_cnt, e.hi, n_period);
        end
        if (len_cnt != e.len) begin
          errors++;
          $display("FAIL period_len actual=%0d required=%0d (period %0d)", len_cnt, e.len, n_period);
        end
        $display("period %0d high=%0d len=%0d", n_period, hi_cnt, len_cnt);
      end
      hi_cnt  = 0;
      len_cnt = 0;
    end
  end

  task automatic probe(input string name, input int act, input int req);
    probe_t p;
    p.name = name;
    p.act  = act;
    p.req  = req;
    chk_q.push_back(p);
  endtask

  task automatic expect_period(input int hi, input int len);
    period_t e;
    e.hi  = hi;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; the instruction is captured on the next posedge.
  task automatic issue(input logic [3:0] code, input logic [7:0] imm);
    inst    = {code, imm};
    inst_en = 1'b1;
    @(posedge clock);
    #1;
    inst_en = 1'b0;
    inst    = 12'h000;
  endtask

  task automatic skip(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_run();
    issue(RUN, 8'h00);
    run_id++;
  endtask

  // Quiet-output window: pwm, period_done and error must stay at the given levels.
  task automatic hold_check(input string name, input int cycles, input logic err_lvl);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (pwm !== 1'b0 || period_done !== 1'b0 || error !== err_lvl) bad++;
      @(posedge clock);
      #1;
    end
    probe(name, bad, 0);
  endtask

  initial begin
    reset   = 1'b1;
    inst    = 12'h000;
    inst_en = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    probe("reset_pwm", int'(pwm), 0);
    probe("reset_period_done", int'(period_done), 0);
    probe("reset_error", int'(error), 0);
    reset = 1'b0;
    skip(1);

    // Duty 40h, presc 0; mid-period LDD C0h, then LDD 20h exactly on a wrap edge.
    issue(LDD, 8'h40);
    start_run();
    expect_period(64, 256);
    expect_period(192, 256);
    expect_period(192, 256);
    expect_period(32, 256);
    skip(16);
    issue(LDD, 8'hC0);
    skip(494);
    issue(LDD, 8'h20);
    skip(511);
    issue(STP, 8'h00);

    // presc 3: 4 clocks per count, 1024-clock period.
    issue(LDP, 8'h03);
    issue(LDD, 8'h80);
    start_run();
    expect_period(512, 1024);
    expect_period(512, 1024);
    skip(2047);
    issue(STP, 8'h00);
    issue(LDP, 8'h00);

    // LDX from data_in, then the 00h and FFh extremes.
    data_in = 8'h5A;
    issue(LDX, 8'h00);
    data_in = 8'h11;
    start_run();
    expect_period(90, 256);
    skip(255);
    issue(STP, 8'h00);
    issue(LDD, 8'h00);
    start_run();
    expect_period(0, 256);
    skip(255);
    issue(STP, 8'h00);
    issue(LDD, 8'hFF);
    start_run();
    expect_period(255, 256);
    skip(255);
    issue(STP, 8'h00);

    // STP at count 30h, quiet while stopped, then a clean restart.
    issue(LDD, 8'h40);
    start_run();
    skip(48);
    issue(STP, 8'h00);
    hold_check("stopped_quiet", 300, 1'b0);
    start_run();
    expect_period(64, 256);
    skip(255);
    issue(STP, 8'h00);

    // Illegal code while running: sticky error until reset.
    start_run();
    skip(20);
    issue(4'h7, 8'h00);
    probe("error_set", int'(error), 1);
    probe("error_pwm", int'(pwm), 0);
    issue(RUN, 8'h00);
    issue(LDD, 8'hFF);
    hold_check("error_sticky", 300, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    probe("reset_clears_error", int'(error), 0);
    reset = 1'b0;
    issue(LDD, 8'hFF);
    // Configuration was lost: duty 0 and presc 0 give a dark 256-clock period.
    start_run();
    expect_period(0, 256);
    skip(255);
    issue(STP, 8'h00);
    probe("after_error_pwm", int'(pwm), 0);

    skip(2);
    probe("pending_periods", exp_q.size(), 0);
    skip(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
